// File: rtl/zx_window_accumulator_pkg.sv
// zx_pkg: shared definitions for the z/x window accumulator slice.
//   - default widths and pipeline latency
//   - window FSM state encoding
package zx_pkg;

   localparam int DATAWIDTH_DEF = 32;
   localparam int ACCWIDTH_DEF  = 48;
   localparam int CNTWIDTH_DEF  = 8;
   localparam int LATENCY_DEF   = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

endpackage

// File: rtl/zx_window_accumulator_if.sv
// zx_window_accumulator_if: groups the sample input side and the result
// valid/ready side of the window accumulator.
//   src_valid, z, x, win_len, flush : sample stream and control into the block
//   out_ready                       : consumer accepts the held result
//   out_valid, z_sum, x_sum, n_out  : held window result
//   overrun                         : sticky dropped-result flag
// modport slave is the accumulator, modport master is its environment.
interface zx_window_accumulator_if
   import zx_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ACCWIDTH  = ACCWIDTH_DEF,
   parameter int CNTWIDTH  = CNTWIDTH_DEF
) ();

   logic                        src_valid;
   logic signed [DATAWIDTH-1:0] z;
   logic signed [DATAWIDTH-1:0] x;
   logic [CNTWIDTH-1:0]         win_len;
   logic                        flush;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [ACCWIDTH-1:0]  z_sum;
   logic signed [ACCWIDTH-1:0]  x_sum;
   logic [CNTWIDTH-1:0]         n_out;
   logic                        overrun;

   modport slave (
      input  src_valid, z, x, win_len, flush, out_ready,
      output out_valid, z_sum, x_sum, n_out, overrun
   );

   modport master (
      output src_valid, z, x, win_len, flush, out_ready,
      input  out_valid, z_sum, x_sum, n_out, overrun
   );

endinterface

// File: rtl/zx_window_accumulator_valid_delay_line.sv
// valid_delay_line: shifts the launch strobe through LATENCY register
// stages so that q lines up with the z/x values leaving circuit4.
//   Clk : rising-edge clock
//   Rst : asynchronous active-high reset, empties the line
//   clr : synchronous clear of every stage (strobe in flight is discarded)
//   d   : launch strobe (stage 0)
//   q   : strobe after LATENCY cycles
// LATENCY must be at least 1.
module valid_delay_line
   import zx_pkg::*;
#(
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [LATENCY:1] vld_q;
   logic [LATENCY:1] vld_d;

   // A clear wipes the whole line, including the strobe arriving this cycle.
   always_comb begin
      vld_d = vld_q;
      if (clr) begin
         vld_d = '0;
      end else begin
         vld_d[1] = d;
         for (int k = 2; k <= LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign q = vld_q[LATENCY];

endmodule

// File: rtl/zx_window_accumulator.sv
// zx_window_accumulator: sums windows of win_len z/x samples from circuit4
// and presents each window result in a one-entry valid/ready register.
//   Clk : rising-edge clock
//   Rst : asynchronous active-high reset
//   bus : zx_window_accumulator_if.slave (samples, control, result, overrun)
// A sample is valid in the cycle the launch strobe emerges from the delay
// line. A window completes in the sample cycle where its count reaches the
// length latched when the window opened; a completion that finds the
// previous result still unaccepted is dropped and sets the sticky overrun.
// ACCWIDTH must be greater than DATAWIDTH.
module zx_window_accumulator
   import zx_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ACCWIDTH  = ACCWIDTH_DEF,
   parameter int CNTWIDTH  = CNTWIDTH_DEF,
   parameter int LATENCY   = LATENCY_DEF
) (
   input logic                     Clk,
   input logic                     Rst,
   zx_window_accumulator_if.slave  bus
);

   logic                       s;
   state_t                     state_q, state_d;
   logic signed [ACCWIDTH-1:0] z_acc_q, z_acc_d;
   logic signed [ACCWIDTH-1:0] x_acc_q, x_acc_d;
   logic [CNTWIDTH-1:0]        cnt_q, cnt_d;
   logic [CNTWIDTH-1:0]        len_q, len_d;
   logic                       out_valid_q, out_valid_d;
   logic signed [ACCWIDTH-1:0] z_sum_q, z_sum_d;
   logic signed [ACCWIDTH-1:0] x_sum_q, x_sum_d;
   logic [CNTWIDTH-1:0]        n_out_q, n_out_d;
   logic                       overrun_q, overrun_d;

   logic signed [ACCWIDTH-1:0] z_ext, x_ext;
   logic signed [ACCWIDTH-1:0] z_next, x_next;
   logic [CNTWIDTH-1:0]        cnt_next;
   logic [CNTWIDTH-1:0]        len_eff;
   logic                       complete;

   valid_delay_line #(
      .LATENCY (LATENCY)
   ) u_delay (
      .Clk (Clk),
      .Rst (Rst),
      .clr (bus.flush),
      .d   (bus.src_valid),
      .q   (s)
   );

   assign z_ext = {{(ACCWIDTH-DATAWIDTH){bus.z[DATAWIDTH-1]}}, bus.z};
   assign x_ext = {{(ACCWIDTH-DATAWIDTH){bus.x[DATAWIDTH-1]}}, bus.x};

   // Running values as they would be after taking this cycle's sample.
   // In IDLE the window is opening, so the sample starts a fresh sum and the
   // length comes straight from win_len (zero meaning one).
   always_comb begin
      z_next   = '0;
      x_next   = '0;
      cnt_next = CNTWIDTH'(1);
      len_eff  = len_q;
      if (state_q == ST_IDLE) begin
         z_next   = z_ext;
         x_next   = x_ext;
         cnt_next = CNTWIDTH'(1);
         len_eff  = (bus.win_len == '0) ? CNTWIDTH'(1) : bus.win_len;
      end else begin
         z_next   = z_acc_q + z_ext;
         x_next   = x_acc_q + x_ext;
         cnt_next = cnt_q + CNTWIDTH'(1);
         len_eff  = len_q;
      end
      complete = s && !bus.flush && (cnt_next == len_eff);
   end

   // Window FSM and accumulators. flush beats a coincident sample; a
   // completing sample returns to IDLE so the next sample opens a new window.
   always_comb begin
      state_d = state_q;
      z_acc_d = z_acc_q;
      x_acc_d = x_acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      if (bus.flush) begin
         state_d = ST_IDLE;
         z_acc_d = '0;
         x_acc_d = '0;
         cnt_d   = '0;
      end else if (s) begin
         if (state_q == ST_IDLE) begin
            len_d = len_eff;
         end
         if (complete) begin
            state_d = ST_IDLE;
            z_acc_d = '0;
            x_acc_d = '0;
            cnt_d   = '0;
         end else begin
            state_d = ST_FILL;
            z_acc_d = z_next;
            x_acc_d = x_next;
            cnt_d   = cnt_next;
         end
      end
   end

   // One-entry result register. A completion loads when the slot is empty or
   // being accepted this cycle, so accept-plus-complete keeps out_valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      z_sum_d     = z_sum_q;
      x_sum_d     = x_sum_q;
      n_out_d     = n_out_q;
      overrun_d   = overrun_q;
      if (complete) begin
         if (!out_valid_q || bus.out_ready) begin
            out_valid_d = 1'b1;
            z_sum_d     = z_next;
            x_sum_d     = x_next;
            n_out_d     = cnt_next;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         z_acc_q     <= '0;
         x_acc_q     <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         out_valid_q <= 1'b0;
         z_sum_q     <= '0;
         x_sum_q     <= '0;
         n_out_q     <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         z_acc_q     <= z_acc_d;
         x_acc_q     <= x_acc_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
         z_sum_q     <= z_sum_d;
         x_sum_q     <= x_sum_d;
         n_out_q     <= n_out_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.z_sum     = z_sum_q;
   assign bus.x_sum     = x_sum_q;
   assign bus.n_out     = n_out_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_zx_window_accumulator.sv
// tb_zx_window_accumulator: directed scoreboard bench for the z/x window
// accumulator. A two-stage stand-in for circuit4 carries launched z/x values
// to the accumulator inputs; expected window results are queued when the
// stimulus is issued and a monitor compares them on each accepted result.
module tb_zx_window_accumulator;
   import zx_pkg::*;

   typedef struct {
      longint zs;
      longint xs;
      longint n;
   } result_t;

   logic Clk = 1'b0;
   logic Rst;

   logic signed [31:0] launch_z, launch_x;
   logic signed [31:0] stage_z, stage_x;

   result_t exp_q[$];
   int      checks = 0;
   int      errors = 0;

   zx_window_accumulator_if bus ();

   zx_window_accumulator dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   // circuit4 stand-in: the launched z/x pair appears two cycles later.
   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stage_z <= '0;
         stage_x <= '0;
         bus.z   <= '0;
         bus.x   <= '0;
      end else begin
         stage_z <= launch_z;
         stage_x <= launch_x;
         bus.z   <= stage_z;
         bus.x   <= stage_x;
      end
   end

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic launch(input int zv, input int xv);
      bus.src_valid = 1'b1;
      launch_z      = zv;
      launch_x      = xv;
      tick();
      bus.src_valid = 1'b0;
      launch_z      = '0;
      launch_x      = '0;
   endtask

   task automatic expect_result(input longint zs, input longint xs, input longint n);
      result_t r;
      r.zs = zs;
      r.xs = xs;
      r.n  = n;
      exp_q.push_back(r);
   endtask

   // Monitor: every accepted result must match the oldest expectation.
   always @(negedge Clk) begin
      result_t r;
      if (!Rst && bus.out_valid && bus.out_ready) begin
         check_output("result_pending", longint'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check_output("z_sum", longint'(bus.z_sum), r.zs);
            check_output("x_sum", longint'(bus.x_sum), r.xs);
            check_output("n_out", longint'(bus.n_out), r.n);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      Rst           = 1'b1;
      bus.src_valid = 1'b0;
      bus.win_len   = 8'd1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      launch_z      = '0;
      launch_x      = '0;
      idle(3);

      // Reset state
      check_output("rst_out_valid", longint'(bus.out_valid), 0);
      check_output("rst_z_sum", longint'(bus.z_sum), 0);
      check_output("rst_x_sum", longint'(bus.x_sum), 0);
      check_output("rst_n_out", longint'(bus.n_out), 0);
      check_output("rst_overrun", longint'(bus.overrun), 0);
      Rst = 1'b0;
      idle(2);

      // Single-sample window and its latency
      expect_result(6, 2, 1);
      launch(6, 2);
      tick();
      @(negedge Clk);
      check_output("t1_valid_t_plus_2", longint'(bus.out_valid), 0);
      tick();
      @(negedge Clk);
      check_output("t1_valid_t_plus_3", longint'(bus.out_valid), 1);
      idle(3);

      // Three-sample window with gaps
      bus.win_len = 8'd3;
      expect_result(18, 6, 3);
      launch(6, 2);
      launch(6, 2);
      idle(2);
      launch(6, 2);
      tick();
      @(negedge Clk);
      check_output("t2_no_early_valid", longint'(bus.out_valid), 0);
      idle(5);

      // Two-sample windows back to back, consumer always ready
      bus.win_len = 8'd2;
      expect_result(3, 30, 2);
      expect_result(-1, -10, 2);
      launch(1, 10);
      launch(2, 20);
      launch(3, 30);
      launch(-4, -40);
      idle(6);
      check_output("t4_overrun_a", longint'(bus.overrun), 0);

      // Single-sample windows back to back: accept and completion coincide
      bus.win_len = 8'd1;
      expect_result(5, 1, 1);
      expect_result(6, 2, 1);
      expect_result(7, 3, 1);
      launch(5, 1);
      launch(6, 2);
      launch(7, 3);
      @(negedge Clk);
      check_output("t4_valid_run0", longint'(bus.out_valid), 1);
      tick();
      @(negedge Clk);
      check_output("t4_valid_run1", longint'(bus.out_valid), 1);
      tick();
      @(negedge Clk);
      check_output("t4_valid_run2", longint'(bus.out_valid), 1);
      idle(4);
      check_output("t4_overrun_b", longint'(bus.overrun), 0);

      // win_len of zero acts as one; mid-window win_len change ignored
      bus.win_len = 8'd0;
      expect_result(11, -3, 1);
      launch(11, -3);
      idle(4);
      bus.win_len = 8'd4;
      expect_result(10, -10, 4);
      launch(1, -1);
      idle(2);
      bus.win_len = 8'd2;
      launch(2, -2);
      launch(3, -3);
      launch(4, -4);
      idle(6);
      bus.win_len = 8'd1;

      // Overrun: consumer stalled across two completions
      bus.out_ready = 1'b0;
      expect_result(6, 2, 1);
      launch(6, 2);
      launch(9, 4);
      idle(3);
      @(negedge Clk);
      check_output("t3_overrun_set", longint'(bus.overrun), 1);
      check_output("t3_held_valid", longint'(bus.out_valid), 1);
      check_output("t3_held_z_sum", longint'(bus.z_sum), 6);
      tick();
      bus.out_ready = 1'b1;
      idle(2);
      @(negedge Clk);
      check_output("t3_overrun_after_ready", longint'(bus.overrun), 1);
      check_output("t3_valid_after_accept", longint'(bus.out_valid), 0);
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      @(negedge Clk);
      check_output("t3_overrun_after_flush", longint'(bus.overrun), 1);
      tick();

      // Asynchronous reset in the middle of a window (two samples in)
      bus.win_len = 8'd4;
      launch(1, 1);
      launch(2, 2);
      idle(2);
      #2;
      Rst = 1'b1;
      #1;
      check_output("t6_async_z_sum", longint'(bus.z_sum), 0);
      check_output("t6_async_x_sum", longint'(bus.x_sum), 0);
      check_output("t6_async_n_out", longint'(bus.n_out), 0);
      check_output("t6_async_overrun", longint'(bus.overrun), 0);
      tick();
      Rst = 1'b0;
      tick();

      // First window after reset counts from one
      bus.win_len = 8'd2;
      expect_result(5, 50, 2);
      launch(2, 20);
      launch(3, 30);
      idle(5);

      // flush in the cycle a sample arrives discards that sample
      expect_result(7, 70, 2);
      launch(100, 100);
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      launch(3, 30);
      launch(4, 40);
      idle(5);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
         tick();
      end
      check_output("scoreboard_drained", longint'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
